// File: rtl/alarm_bank.sv
// Bank of programmable alarm channels with snooze, stop and ring timeout.
// Each channel is one alarm_chan instance. All channels share the minute-tick detector.

module alarm_chan #(
   parameter int SNOOZE_MIN = 5,
   parameter int RING_MIN   = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [4:0] i_hour,
   input  logic [5:0] i_min,
   input  logic       i_tick,
   input  logic       i_wr,
   input  logic [4:0] i_wr_hour,
   input  logic [5:0] i_wr_min,
   input  logic       i_wr_ena,
   input  logic       i_snooze,
   input  logic       i_stop,
   output logic       o_hit,
   output logic       o_ring
);
   typedef enum logic [1:0] {S_IDLE, S_RING, S_SNZ} state_t;

   state_t     r_state, w_state_nx;
   logic [4:0] r_ah, r_th, w_th;
   logic [5:0] r_am, r_tm, w_tm;
   logic       r_ena, r_m_prev, r_t_prev, r_hit;
   logic [3:0] r_timer, w_timer_nx;
   logic       w_m, w_rise, w_tmatch, w_trise, w_latch;
   logic [6:0] w_sum;

   always_comb begin
      w_m      = r_ena && (i_hour == r_ah) && (i_min == r_am);
      w_rise   = w_m && !r_m_prev;
      w_tmatch = (i_hour == r_th) && (i_min == r_tm);
      w_trise  = w_tmatch && !r_t_prev;
      // Snooze target is now + SNOOZE_MIN, carrying into the hour and wrapping at midnight.
      w_sum    = {1'b0, i_min} + 7'(SNOOZE_MIN);
      w_tm     = 6'(w_sum);
      w_th     = i_hour;
      if (w_sum >= 7'd60) begin
         w_tm = 6'(w_sum - 7'd60);
         w_th = (i_hour == 5'd23) ? 5'd0 : 5'(i_hour + 5'd1);
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_timer_nx = r_timer;
      w_latch    = 1'b0;
      if (i_wr) begin
         w_state_nx = S_IDLE;
         w_timer_nx = '0;
      end else if (i_stop) begin
         w_state_nx = S_IDLE;
         w_timer_nx = '0;
      end else if (i_snooze && r_state == S_RING) begin
         w_state_nx = S_SNZ;
         w_timer_nx = '0;
         w_latch    = 1'b1;
      end else if (w_rise || (r_state == S_SNZ && w_trise)) begin
         w_state_nx = S_RING;
         w_timer_nx = '0;
      end else if (r_state == S_RING && i_tick) begin
         if (r_timer == 4'(RING_MIN - 1)) begin
            w_state_nx = S_IDLE;
            w_timer_nx = '0;
         end else begin
            w_timer_nx = r_timer + 4'd1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_timer  <= '0;
         r_ah     <= '0;
         r_am     <= '0;
         r_ena    <= 1'b0;
         r_th     <= '0;
         r_tm     <= '0;
         r_m_prev <= 1'b0;
         r_t_prev <= 1'b0;
         r_hit    <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_timer  <= w_timer_nx;
         r_hit    <= w_rise;
         r_m_prev <= i_wr ? 1'b0 : w_m;
         r_t_prev <= (i_wr || w_latch) ? 1'b0 : w_tmatch;
         if (i_wr) begin
            r_ah  <= i_wr_hour;
            r_am  <= i_wr_min;
            r_ena <= i_wr_ena;
         end
         if (w_latch) begin
            r_th <= w_th;
            r_tm <= w_tm;
         end
      end
   end

   assign o_hit  = r_hit;
   assign o_ring = (r_state == S_RING);
endmodule

module alarm_bank #(
   parameter int N_ALARMS   = 4,
   parameter int SNOOZE_MIN = 5,
   parameter int RING_MIN   = 2,
   parameter int IDX_W      = $clog2(N_ALARMS)
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [4:0]          i_hour,
   input  logic [5:0]          i_min,
   input  logic                i_wr_en,
   input  logic [IDX_W-1:0]    i_wr_idx,
   input  logic [4:0]          i_wr_hour,
   input  logic [5:0]          i_wr_min,
   input  logic                i_wr_ena,
   input  logic                i_snooze,
   input  logic                i_stop,
   output logic [N_ALARMS-1:0] o_hit,
   output logic [N_ALARMS-1:0] o_ring,
   output logic                o_ringing,
   output logic [IDX_W-1:0]    o_ring_id
);
   logic [5:0]          r_min_prev;
   logic                w_tick;
   logic [N_ALARMS-1:0] w_wr;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_min_prev <= '0;
      else       r_min_prev <= i_min;
   end

   assign w_tick = (i_min != r_min_prev);

   for (genvar g = 0; g < N_ALARMS; g++) begin : g_chan
      assign w_wr[g] = i_wr_en && (i_wr_idx == IDX_W'(g));
      alarm_chan #(.SNOOZE_MIN(SNOOZE_MIN), .RING_MIN(RING_MIN)) u_chan (
         .i_clk     (i_clk),
         .i_rst     (i_rst),
         .i_hour    (i_hour),
         .i_min     (i_min),
         .i_tick    (w_tick),
         .i_wr      (w_wr[g]),
         .i_wr_hour (i_wr_hour),
         .i_wr_min  (i_wr_min),
         .i_wr_ena  (i_wr_ena),
         .i_snooze  (i_snooze),
         .i_stop    (i_stop),
         .o_hit     (o_hit[g]),
         .o_ring    (o_ring[g])
      );
   end

   assign o_ringing = |o_ring;

   // Walk from the top down so the lowest ringing index wins.
   always_comb begin
      o_ring_id = '0;
      for (int i = N_ALARMS - 1; i >= 0; i--)
         if (o_ring[i]) o_ring_id = IDX_W'(i);
   end
endmodule

// File: tb/tb_alarm_bank.sv
// Directed test of alarm_bank: match edge, snooze wrap, timeout, priority, write, reset.
`timescale 1ns/1ps
module tb_alarm_bank;
   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] hour;
   logic [5:0] min;
   logic       wr_en;
   logic [1:0] wr_idx;
   logic [4:0] wr_hour;
   logic [5:0] wr_min;
   logic       wr_ena;
   logic       snooze;
   logic       stop;
   logic [3:0] hit;
   logic [3:0] ring;
   logic       ringing;
   logic [1:0] ring_id;

   int n_assert = 0;
   int n_fail   = 0;

   alarm_bank #(.N_ALARMS(4), .SNOOZE_MIN(5), .RING_MIN(2)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_hour    (hour),
      .i_min     (min),
      .i_wr_en   (wr_en),
      .i_wr_idx  (wr_idx),
      .i_wr_hour (wr_hour),
      .i_wr_min  (wr_min),
      .i_wr_ena  (wr_ena),
      .i_snooze  (snooze),
      .i_stop    (stop),
      .o_hit     (hit),
      .o_ring    (ring),
      .o_ringing (ringing),
      .o_ring_id (ring_id)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] idx, input logic [4:0] h, input logic [5:0] m,
                     input logic e);
      wr_en = 1'b1; wr_idx = idx; wr_hour = h; wr_min = m; wr_ena = e;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic settime(input logic [4:0] h, input logic [5:0] m);
      hour = h; min = m;
      tick();
   endtask

   task automatic pulse_stop();
      stop = 1'b1; tick(); stop = 1'b0;
   endtask

   initial begin
      int hits;
      rst = 1'b1; hour = '0; min = '0; wr_en = 1'b0; wr_idx = '0;
      wr_hour = '0; wr_min = '0; wr_ena = 1'b0; snooze = 1'b0; stop = 1'b0;
      tick(); tick();
      chk("rst_hit", 8'(hit), 8'h0);
      chk("rst_ring", 8'(ring), 8'h0);
      chk("rst_ringing", 8'(ringing), 8'h0);
      chk("rst_ring_id", 8'(ring_id), 8'h0);
      rst = 1'b0;

      // 1: primary match, single pulse on a held level
      wr(2'd1, 5'd7, 6'd30, 1'b1);
      settime(5'd7, 6'd29);
      chk("t1_prehit", 8'(hit), 8'h0);
      settime(5'd7, 6'd30);
      chk("t1_hit", 8'(hit), 8'h02);
      chk("t1_ring", 8'(ring), 8'h02);
      chk("t1_ringing", 8'(ringing), 8'h1);
      chk("t1_ring_id", 8'(ring_id), 8'h1);
      tick();
      chk("t1_hit_drop", 8'(hit), 8'h0);
      hits = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (hit != 4'h0) hits++;
      end
      chk("t1_no_rehit", 8'(hits), 8'h0);
      chk("t1_still_ring", 8'(ring), 8'h02);
      pulse_stop();
      chk("t1_stop", 8'(ring), 8'h0);

      // 2: snooze across midnight, target match does not pulse hit
      wr(2'd0, 5'd23, 6'd58, 1'b1);
      settime(5'd23, 6'd57);
      settime(5'd23, 6'd58);
      chk("t2_hit", 8'(hit), 8'h01);
      chk("t2_ring", 8'(ring), 8'h01);
      snooze = 1'b1; tick(); snooze = 1'b0;
      chk("t2_snoozed", 8'(ring), 8'h0);
      settime(5'd23, 6'd59);
      settime(5'd0, 6'd0);
      settime(5'd0, 6'd1);
      settime(5'd0, 6'd2);
      chk("t2_wait", 8'(ring), 8'h0);
      settime(5'd0, 6'd3);
      chk("t2_rering", 8'(ring), 8'h01);
      chk("t2_no_hit", 8'(hit), 8'h0);
      tick();
      chk("t2_no_hit_late", 8'(hit), 8'h0);
      pulse_stop();

      // 3: ring timeout after two minute ticks
      wr(2'd2, 5'd10, 6'd0, 1'b1);
      settime(5'd9, 6'd59);
      settime(5'd10, 6'd0);
      chk("t3_ring", 8'(ring), 8'h04);
      settime(5'd10, 6'd1);
      chk("t3_tick1", 8'(ring), 8'h04);
      settime(5'd10, 6'd2);
      chk("t3_timeout", 8'(ring), 8'h0);

      // 4: simultaneous match, stop beats snooze
      wr(2'd0, 5'd11, 6'd15, 1'b1);
      wr(2'd3, 5'd11, 6'd15, 1'b1);
      settime(5'd11, 6'd14);
      settime(5'd11, 6'd15);
      chk("t4_hit", 8'(hit), 8'h09);
      chk("t4_ring", 8'(ring), 8'h09);
      chk("t4_ring_id", 8'(ring_id), 8'h0);
      stop = 1'b1; snooze = 1'b1; tick(); stop = 1'b0; snooze = 1'b0;
      chk("t4_idle", 8'(ring), 8'h0);
      chk("t4_ringing", 8'(ringing), 8'h0);

      // 5: write outranks snooze; writing the current time triggers a hit
      settime(5'd7, 6'd29);
      settime(5'd7, 6'd30);
      chk("t5_ring", 8'(ring), 8'h02);
      wr_en = 1'b1; wr_idx = 2'd1; wr_hour = 5'd7; wr_min = 6'd31; wr_ena = 1'b1;
      snooze = 1'b1; tick(); wr_en = 1'b0; snooze = 1'b0;
      chk("t5_wr_idle", 8'(ring), 8'h0);
      wr(2'd1, 5'd7, 6'd30, 1'b1);
      chk("t5_cfg_nohit", 8'(hit), 8'h0);
      tick();
      chk("t5_hit", 8'(hit), 8'h02);
      chk("t5_ring2", 8'(ring), 8'h02);

      // 6: reset aborts ringing and snoozed channels and clears enables
      pulse_stop();
      wr(2'd0, 5'd7, 6'd32, 1'b1);
      settime(5'd7, 6'd32);
      chk("t6_ch0_ring", 8'(ring), 8'h01);
      snooze = 1'b1; tick(); snooze = 1'b0;
      wr(2'd1, 5'd7, 6'd33, 1'b1);
      settime(5'd7, 6'd33);
      chk("t6_ch1_ring", 8'(ring), 8'h02);
      rst = 1'b1; tick();
      chk("t6_rst_hit", 8'(hit), 8'h0);
      chk("t6_rst_ring", 8'(ring), 8'h0);
      chk("t6_rst_ringing", 8'(ringing), 8'h0);
      chk("t6_rst_id", 8'(ring_id), 8'h0);
      rst = 1'b0;
      settime(5'd7, 6'd37);
      tick();
      chk("t6_no_snz_ring", 8'(ring), 8'h0);
      settime(5'd7, 6'd32);
      chk("t6_no_hit0", 8'(hit), 8'h0);
      settime(5'd7, 6'd33);
      chk("t6_no_hit1", 8'(hit), 8'h0);
      chk("t6_no_ring", 8'(ring), 8'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
